// File: rtl/or_mon_pkg.sv
// Shared types for the OR-gate event monitor: debounce FSM states and
// the width helper for the debounce counter.
package or_mon_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        CHK_HIGH  = 2'd1,
        IDLE_HIGH = 2'd2,
        CHK_LOW   = 2'd3
    } dbnc_state_t;

    // Enough bits to hold the value DEBOUNCE_CYCLES itself.
    function automatic int dcnt_width(input int debounce_cycles);
        return $clog2(debounce_cycles + 1);
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer bringing a single asynchronous bit into the clk domain.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/or_event_monitor.sv
// Synchronizes and debounces the OR gate output, counts qualified rising edges
// and offers each event through a one-deep valid/ready holding register.
module or_event_monitor
    import or_mon_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             z_in,
    input  logic             clear,
    output logic             level_out,
    output logic             rise_pulse,
    output logic [CNT_W-1:0] evt_count,
    output logic             count_sat,
    output logic             evt_valid,
    output logic [CNT_W-1:0] evt_data,
    input  logic             evt_ready,
    output logic             overflow
);

    localparam int                DCNT_W   = dcnt_width(DEBOUNCE_CYCLES);
    localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(DEBOUNCE_CYCLES);
    localparam logic [DCNT_W-1:0] DCNT_ONE = DCNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    // Handshake: an event transfers on any edge where evt_valid && evt_ready;
    // evt_data is held stable while evt_valid is high and evt_ready is low.

    dbnc_state_t       state;
    logic [DCNT_W-1:0] dcnt;
    logic              z_s;
    logic              accept_rise;
    logic [CNT_W-1:0]  next_count;

    bit_synchronizer #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (z_in),
        .q    (z_s)
    );

    always_comb begin
        accept_rise = 1'b0;
        if (z_s) begin
            if ((DEBOUNCE_CYCLES == 1) && (state == IDLE_LOW)) begin
                accept_rise = 1'b1;
            end
            if ((state == CHK_HIGH) && (dcnt == DCNT_MAX)) begin
                accept_rise = 1'b1;
            end
        end
    end

    // Clear forces the offered value to zero even when a rise lands on the same edge.
    always_comb begin
        next_count = evt_count;
        if (clear) begin
            next_count = '0;
        end else if (evt_count != CNT_MAX) begin
            next_count = evt_count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE_LOW;
            dcnt       <= '0;
            level_out  <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            rise_pulse <= accept_rise;
            case (state)
                IDLE_LOW: begin
                    if (z_s) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state     <= IDLE_HIGH;
                            dcnt      <= '0;
                            level_out <= 1'b1;
                        end else begin
                            state <= CHK_HIGH;
                            dcnt  <= DCNT_ONE;
                        end
                    end
                end
                CHK_HIGH: begin
                    if (!z_s) begin
                        state <= IDLE_LOW;
                        dcnt  <= '0;
                    end else if (dcnt == DCNT_MAX) begin
                        state     <= IDLE_HIGH;
                        dcnt      <= '0;
                        level_out <= 1'b1;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                IDLE_HIGH: begin
                    if (!z_s) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state     <= IDLE_LOW;
                            dcnt      <= '0;
                            level_out <= 1'b0;
                        end else begin
                            state <= CHK_LOW;
                            dcnt  <= DCNT_ONE;
                        end
                    end
                end
                CHK_LOW: begin
                    if (z_s) begin
                        state <= IDLE_HIGH;
                        dcnt  <= '0;
                    end else if (dcnt == DCNT_MAX) begin
                        state     <= IDLE_LOW;
                        dcnt      <= '0;
                        level_out <= 1'b0;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE_LOW;
                    dcnt      <= '0;
                    level_out <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_count <= '0;
            count_sat <= 1'b0;
        end else if (clear) begin
            evt_count <= '0;
            count_sat <= 1'b0;
        end else if (accept_rise) begin
            if (evt_count == CNT_MAX) begin
                count_sat <= 1'b1;
            end else begin
                evt_count <= next_count;
            end
        end
    end

    // A rise arriving while the held event is unread is dropped and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid <= 1'b0;
            evt_data  <= '0;
            overflow  <= 1'b0;
        end else begin
            if (accept_rise) begin
                if (!evt_valid || evt_ready) begin
                    evt_valid <= 1'b1;
                    evt_data  <= next_count;
                end else if (!clear) begin
                    overflow <= 1'b1;
                end
            end else if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end
            if (clear) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_or_event_monitor.sv
// Directed bench for or_event_monitor: default instance plus a 2-bit counter
// instance for saturation and clear.
module tb_or_event_monitor;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, z_in, clear, evt_ready;
  logic       level_out, rise_pulse, count_sat, evt_valid, overflow;
  logic [7:0] evt_count, evt_data;

  logic       rst_b_n, z_b, clear_b, ready_b;
  logic       level_b, rise_b, sat_b, valid_b, ovf_b;
  logic [1:0] count_b, data_b;

  int total = 0;
  int bad   = 0;
  logic seen_pulse, seen_level, seen_valid;

  or_event_monitor dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .z_in      (z_in),
    .clear     (clear),
    .level_out (level_out),
    .rise_pulse(rise_pulse),
    .evt_count (evt_count),
    .count_sat (count_sat),
    .evt_valid (evt_valid),
    .evt_data  (evt_data),
    .evt_ready (evt_ready),
    .overflow  (overflow)
  );

  or_event_monitor #(.CNT_W(2)) dut_b (
    .clk       (clk),
    .rst_n     (rst_b_n),
    .z_in      (z_b),
    .clear     (clear_b),
    .level_out (level_b),
    .rise_pulse(rise_b),
    .evt_count (count_b),
    .count_sat (sat_b),
    .evt_valid (valid_b),
    .evt_data  (data_b),
    .evt_ready (ready_b),
    .overflow  (ovf_b)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_b();
    z_b = 1'b1;
    tick(7);
    z_b = 1'b0;
    tick(8);
  endtask

  initial begin
    rst_n = 1'b0; z_in = 1'b0; clear = 1'b0; evt_ready = 1'b0;
    rst_b_n = 1'b0; z_b = 1'b0; clear_b = 1'b0; ready_b = 1'b1;
    tick(2);
    check("rst_level", level_out, 0);
    check("rst_rise", rise_pulse, 0);
    check("rst_count", evt_count, 0);
    check("rst_sat", count_sat, 0);
    check("rst_valid", evt_valid, 0);
    check("rst_data", evt_data, 0);
    check("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    rst_b_n = 1'b1;
    tick(2);

    // Glitch: two captured high samples are not enough to qualify.
    seen_pulse = 0; seen_level = 0; seen_valid = 0;
    z_in = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i == 2) z_in = 1'b0;
      tick(1);
      seen_pulse |= rise_pulse;
      seen_level |= level_out;
      seen_valid |= evt_valid;
    end
    check("glitch_pulse", seen_pulse, 0);
    check("glitch_level", seen_level, 0);
    check("glitch_valid", seen_valid, 0);
    check("glitch_count", evt_count, 0);

    // Clean rising edge: pulse exactly 6 edges after capture.
    z_in = 1'b1;
    tick(6);
    check("clean_pre_rise", rise_pulse, 0);
    check("clean_pre_level", level_out, 0);
    tick(1);
    check("clean_rise", rise_pulse, 1);
    check("clean_level", level_out, 1);
    check("clean_count", evt_count, 1);
    check("clean_valid", evt_valid, 1);
    check("clean_data", evt_data, 1);
    tick(1);
    check("clean_rise_one_cycle", rise_pulse, 0);
    z_in = 1'b0;
    seen_pulse = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      seen_pulse |= rise_pulse;
    end
    check("fall_pre_level", level_out, 1);
    tick(1);
    check("fall_level", level_out, 0);
    check("fall_no_pulse", seen_pulse | rise_pulse, 0);

    // Backpressure: second rise dropped, held data stays at 1.
    z_in = 1'b1;
    tick(7);
    check("bp_rise", rise_pulse, 1);
    check("bp_count", evt_count, 2);
    check("bp_data", evt_data, 1);
    check("bp_valid", evt_valid, 1);
    check("bp_ovf", overflow, 1);
    z_in = 1'b0;
    tick(8);
    check("bp_data_held", evt_data, 1);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    check("bp_drain_valid", evt_valid, 0);

    // Clear resets count and overflow only.
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("clr_count", evt_count, 0);
    check("clr_ovf", overflow, 0);
    check("clr_level", level_out, 0);

    // Accept-and-load on the same edge.
    z_in = 1'b1;
    tick(7);
    check("al_first_data", evt_data, 1);
    check("al_first_valid", evt_valid, 1);
    z_in = 1'b0;
    tick(8);
    z_in = 1'b1;
    tick(6);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    check("al_rise", rise_pulse, 1);
    check("al_data", evt_data, 2);
    check("al_valid", evt_valid, 1);
    check("al_ovf", overflow, 0);
    check("al_count", evt_count, 2);
    z_in = 1'b0;
    tick(8);

    // Reset while in CHK_HIGH with dcnt=2.
    z_in = 1'b1;
    tick(4);
    rst_n = 1'b0;
    #2;
    check("midrst_valid", evt_valid, 0);
    check("midrst_count", evt_count, 0);
    check("midrst_data", evt_data, 0);
    check("midrst_level", level_out, 0);
    check("midrst_rise", rise_pulse, 0);
    rst_n = 1'b1;
    tick(6);
    check("midrst_pre_rise", rise_pulse, 0);
    tick(1);
    check("midrst_rise_after", rise_pulse, 1);
    check("midrst_count_after", evt_count, 1);
    z_in = 1'b0;
    tick(8);

    // Saturation and clear on the 2-bit instance.
    pulse_b();
    pulse_b();
    pulse_b();
    check("sat_count3", count_b, 3);
    check("sat_flag_pre", sat_b, 0);
    pulse_b();
    check("sat_count_hold", count_b, 3);
    check("sat_flag", sat_b, 1);
    check("sat_data", data_b, 3);
    z_b = 1'b1;
    tick(6);
    clear_b = 1'b1;
    tick(1);
    clear_b = 1'b0;
    check("satclr_rise", rise_b, 1);
    check("satclr_count", count_b, 0);
    check("satclr_flag", sat_b, 0);
    check("satclr_ovf", ovf_b, 0);
    check("satclr_data", data_b, 0);
    check("satclr_valid", valid_b, 1);
    z_b = 1'b0;
    tick(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
